// File: rtl/dmem_mover_pkg.sv
// Shared types and default widths for the data-memory block mover.
package dmem_mover_pkg;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } mover_state_t;

    typedef enum logic {
        FWD = 1'b0,
        BWD = 1'b1
    } mover_dir_t;

endpackage

// File: rtl/dmem_block_mover.sv
// Memmove engine for the 8x256 data memory: alternating read/write, 2 cycles per byte.
// Optional byte checksum built only when DMEM_MOVER_CSUM_EN is defined.
module dmem_block_mover
    import dmem_mover_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [ADDR_W-1:0] len,
    output logic              busy,
    output logic              done,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] csum
);

    mover_state_t      state_q;
    mover_dir_t        dir_q;
    logic [ADDR_W-1:0] src_q, dst_q, len_q, off_q, off_d;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic              busy_q, done_q, rd_q, wr_q;

    logic [ADDR_W-1:0] start_diff, start_off;
    logic              start_bwd, last_byte;

    // A destination starting strictly inside the source range must copy from the top down.
    always_comb begin
        start_diff = dst_addr - src_addr;
        start_bwd  = (start_diff != '0) && (start_diff < len);
        start_off  = start_bwd ? (len - ADDR_W'(1)) : '0;
        last_byte  = (dir_q == FWD) ? (off_q == len_q - ADDR_W'(1)) : (off_q == '0);
        off_d      = (dir_q == FWD) ? (off_q + ADDR_W'(1)) : (off_q - ADDR_W'(1));
    end

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            dir_q   <= FWD;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            off_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        src_q <= src_addr;
                        dst_q <= dst_addr;
                        len_q <= len;
                        dir_q <= start_bwd ? BWD : FWD;
                        off_q <= start_off;
                        if (len == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= RD;
                            busy_q  <= 1'b1;
                            rd_q    <= 1'b1;
                            addr_q  <= src_addr + start_off;
                        end
                    end
                end
                RD: begin
                    data_q  <= mem_rdata;
                    rd_q    <= 1'b0;
                    wr_q    <= 1'b1;
                    addr_q  <= dst_q + off_q;
                    state_q <= WR;
                end
                WR: begin
                    wr_q  <= 1'b0;
                    off_q <= off_d;
                    if (last_byte) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= RD;
                        rd_q    <= 1'b1;
                        addr_q  <= src_q + off_d;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign mem_read  = rd_q;
    assign mem_write = wr_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = data_q;

`ifdef DMEM_MOVER_CSUM_EN
    logic [DATA_W-1:0] csum_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            csum_q <= '0;
        end else if (state_q == IDLE && start) begin
            csum_q <= '0;
        end else if (state_q == RD) begin
            csum_q <= csum_q + mem_rdata;
        end
    end

    assign csum = csum_q;
`else
    assign csum = '0;
`endif

endmodule

// File: tb/tb_dmem_block_mover.sv
// Randomized bench for dmem_block_mover against a per-cycle memmove reference trace.
module tb_dmem_block_mover;

    logic       clk = 1'b0;
    logic       reset, start;
    logic [7:0] src_addr, dst_addr, len;
    logic       busy, done, mem_read, mem_write;
    logic [7:0] mem_addr, mem_wdata, mem_rdata, csum;

    dmem_block_mover #(.DATA_W(8), .ADDR_W(8)) dut (
        .clk(clk), .reset(reset), .start(start),
        .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
        .busy(busy), .done(done), .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .csum(csum)
    );

    always #5 clk = ~clk;

    // 256x8 memory: combinational read, posedge write; a side port loads test data.
    logic [7:0] mem [256];
    logic [7:0] ref_mem [256];
    logic       ld_en = 1'b0;
    logic [7:0] ld_addr = '0, ld_data = '0;

    assign mem_rdata = mem_read ? mem[mem_addr] : 8'h00;

    always @(posedge clk) begin
        if (mem_write) mem[mem_addr] <= mem_wdata;
        else if (ld_en) mem[ld_addr] <= ld_data;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        int         cyc;
        logic [27:0] v;   // {busy, done, rd, wr, addr, wdata, csum}
    } exp_t;

    exp_t       exp_q[$];
    logic       chk_en = 1'b0;
    logic [7:0] hold_addr = '0, hold_wdata = '0, hold_csum = '0;
    int         cur_cyc = 0;
    int         done_cnt = 0;
    int         done_at = -1;
    logic [7:0] rd_log[$], wr_log[$];

    function automatic logic [27:0] pack(input logic b, input logic dn, input logic r, input logic w,
                                         input logic [7:0] a, input logic [7:0] wd, input logic [7:0] cs);
        return {b, dn, r, w, a, wd, cs};
    endfunction

    function automatic logic [7:0] csum_exp(input logic [7:0] s);
`ifdef DMEM_MOVER_CSUM_EN
        return s;
`else
        return 8'h00 & s;
`endif
    endfunction

    // Single compare process: every cycle, against the queued trace or the idle expectation.
    always @(negedge clk) begin
        exp_t        e;
        logic [27:0] act;
        if (chk_en) begin
            act = {busy, done, mem_read, mem_write, mem_addr, mem_wdata, csum};
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                hold_addr  = e.v[23:16];
                hold_wdata = e.v[15:8];
                hold_csum  = e.v[7:0];
                check($sformatf("trace_cyc%0d", e.cyc), 64'(act), 64'(e.v));
            end else begin
                check("idle", 64'(act), 64'({4'b0000, hold_addr, hold_wdata, hold_csum}));
            end
            if (mem_read)  rd_log.push_back(mem_addr);
            if (mem_write) wr_log.push_back(mem_addr);
            if (done) begin
                done_cnt++;
                done_at = cur_cyc;
            end
        end
    end

    task automatic poke_mem(input logic [7:0] a, input logic [7:0] v);
        ld_en = 1'b1; ld_addr = a; ld_data = v;
        @(posedge clk); #1;
        ld_en = 1'b0;
        ref_mem[a] = v;
    endtask

    task automatic check_mem_image(input string name);
        int diffs = 0;
        int first = -1;
        for (int a = 0; a < 256; a++) begin
            if (mem[a] !== ref_mem[a]) begin
                diffs++;
                if (first < 0) first = a;
            end
        end
        if (first >= 0) $display("first memory difference at %0d: %h vs %h", first, mem[first], ref_mem[first]);
        check(name, 64'(diffs), 64'd0);
    endtask

    // Starts a copy, queues the expected per-cycle outputs, optionally pulses a stray start
    // (poke_at) or asserts reset (reset_at), then updates the reference memory image.
    task automatic run_copy(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l,
                            input int poke_at, input int reset_at);
        int         n, dd, last_cyc, nwr, i;
        logic       bwd;
        logic [7:0] snap[256];
        logic [7:0] run_sum, pw, pa, ra, wa;
        exp_t       tr[$];
        exp_t       e;
        rd_log.delete(); wr_log.delete();
        done_cnt = 0; done_at = -1; cur_cyc = 0;
        src_addr = s; dst_addr = d; len = l; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;

        n   = int'(l);
        dd  = (int'(d) - int'(s)) & 255;
        bwd = (dd >= 1) && (dd < n);
        for (int k = 0; k < n; k++) snap[k] = ref_mem[(int'(s) + k) & 255];
        pa = hold_addr; pw = hold_wdata; run_sum = 8'h00;
        for (int k = 0; k < n; k++) begin
            i  = bwd ? (n - 1 - k) : k;
            ra = 8'(int'(s) + i);
            wa = 8'(int'(d) + i);
            tr.push_back('{2*k+1, pack(1'b1, 1'b0, 1'b1, 1'b0, ra, pw, csum_exp(run_sum))});
            run_sum = run_sum + snap[i];
            pw = snap[i];
            pa = wa;
            tr.push_back('{2*k+2, pack(1'b1, 1'b0, 1'b0, 1'b1, wa, pw, csum_exp(run_sum))});
        end
        tr.push_back('{2*n+1, pack(1'b0, 1'b1, 1'b0, 1'b0, pa, pw, csum_exp(run_sum))});
        foreach (tr[j]) if (reset_at <= 0 || tr[j].cyc <= reset_at) exp_q.push_back(tr[j]);
        if (reset_at > 0) begin
            e.cyc = reset_at + 1; e.v = '0;
            exp_q.push_back(e);
        end

        last_cyc = (reset_at > 0) ? reset_at + 1 : 2*n + 2;
        for (int c = 1; c <= last_cyc; c++) begin
            cur_cyc = c;
            if (c == poke_at) begin
                start    = 1'b1;
                src_addr = 8'($urandom);
                dst_addr = 8'($urandom);
                len      = 8'($urandom_range(1, 255));
            end
            if (c == poke_at + 1) start = 1'b0;
            if (reset_at > 0 && c == reset_at) reset = 1'b1;
            if (reset_at > 0 && c == reset_at + 1) begin
                reset = 1'b0;
                check("reset_mid_copy", 64'({busy, done, mem_read, mem_write, mem_addr, mem_wdata, csum}), 64'd0);
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        cur_cyc = last_cyc + 1;
        check("trace_drained", 64'(exp_q.size()), 64'd0);

        nwr = (reset_at > 0) ? ((reset_at / 2 < n) ? reset_at / 2 : n) : n;
        for (int k = 0; k < nwr; k++) begin
            i = bwd ? (n - 1 - k) : k;
            ref_mem[(int'(d) + i) & 255] = snap[i];
        end
        check_mem_image("mem_image");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] s, d, l;
        int         mode;
        reset = 1'b1; start = 1'b0;
        src_addr = '0; dst_addr = '0; len = '0;
        @(posedge clk); #1;
        chk_en = 1'b1;
        check("reset_state", 64'({busy, done, mem_read, mem_write, mem_addr, mem_wdata, csum}), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        for (int a = 0; a < 256; a++) poke_mem(8'(a), 8'($urandom));

        // Basic copy.
        poke_mem(8'd10, 8'd11); poke_mem(8'd11, 8'd22); poke_mem(8'd12, 8'd33); poke_mem(8'd13, 8'd44);
        run_copy(8'd10, 8'd100, 8'd4, 0, 0);
        check("t1_mem100", 64'(mem[100]), 64'd11);
        check("t1_mem101", 64'(mem[101]), 64'd22);
        check("t1_mem102", 64'(mem[102]), 64'd33);
        check("t1_mem103", 64'(mem[103]), 64'd44);
        check("t1_done_cycle", 64'(done_at), 64'd9);
`ifdef DMEM_MOVER_CSUM_EN
        check("t1_csum", 64'(csum), 64'h6E);
`else
        check("t1_csum", 64'(csum), 64'h00);
`endif

        // Overlap, destination above source: backward.
        for (int k = 0; k < 5; k++) poke_mem(8'(20 + k), 8'(k + 1));
        run_copy(8'd20, 8'd22, 8'd5, 0, 0);
        for (int k = 0; k < 5; k++) check($sformatf("t2_mem%0d", 22 + k), 64'(mem[22 + k]), 64'(k + 1));
        check("t2_first_write", 64'(wr_log[0]), 64'd26);

        // Overlap, destination below source: forward.
        run_copy(8'd22, 8'd20, 8'd5, 0, 0);
        for (int k = 0; k < 5; k++) check($sformatf("t3_mem%0d", 20 + k), 64'(mem[20 + k]), 64'(k + 1));
        check("t3_first_write", 64'(wr_log[0]), 64'd20);

        // Address wrap, then zero length.
        run_copy(8'hFE, 8'h40, 8'd3, 0, 0);
        check("t4_rd0", 64'(rd_log[0]), 64'hFE);
        check("t4_rd1", 64'(rd_log[1]), 64'hFF);
        check("t4_rd2", 64'(rd_log[2]), 64'h00);
        run_copy(8'h33, 8'h77, 8'd0, 0, 0);
        check("t4_len0_done_cycle", 64'(done_at), 64'd1);
        check("t4_len0_no_access", 64'(rd_log.size() + wr_log.size()), 64'd0);

        // Reset in cycle 5 of an 8-byte copy, then a normal copy.
        run_copy(8'd120, 8'd180, 8'd8, 0, 5);
        run_copy(8'd120, 8'd180, 8'd8, 0, 0);
        check("t5_done_cycle", 64'(done_at), 64'd17);

        // Stray start while busy and in DONE.
        run_copy(8'd30, 8'd60, 8'd6, 4, 0);
        check("t6_done_once", 64'(done_cnt), 64'd1);
        run_copy(8'd70, 8'd71, 8'd3, 7, 0);
        check("t6_done_in_done", 64'(done_cnt), 64'd1);

        // src == dst.
        run_copy(8'd90, 8'd90, 8'd4, 0, 0);

        // Random copies, mixing overlap directions, wrap and stray starts.
        for (int t = 0; t < 24; t++) begin
            s    = 8'($urandom);
            l    = 8'($urandom_range(0, 24));
            mode = $urandom_range(0, 2);
            if (mode == 0)      d = 8'($urandom);
            else if (mode == 1) d = s + 8'($urandom_range(1, 24));
            else                d = s - 8'($urandom_range(1, 24));
            run_copy(s, d, l, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2*int'(l) + 1) : 0, 0);
            check("rand_done_once", 64'(done_cnt), 64'd1);
        end

        repeat (2) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
